// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath and its coefficient loader.
package fir_pkg;

  localparam int FIR_COEF_WIDTH = 16;
  localparam int FIR_MAX_TAPS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DRAIN
  } loader_state_t;

endpackage

// File: rtl/fir_coeff_loader.sv
// Coefficient loader: buffers one host coefficient set in a shadow bank, then
// rewrites every FIR tap in one burst while gating sample valids to the FIR.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for the first beat of a set (cnt = 0)
// ST_COLLECT | storing beats into the shadow bank
// ST_WRITE   | driving one tap per cycle, index 0..MAX_TAPS-1, zero-filled
// ST_DRAIN   | set was too long; discarding beats up to and including last
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int COEF_WIDTH = FIR_COEF_WIDTH,
  parameter int MAX_TAPS   = FIR_MAX_TAPS,
  localparam int IDX_W     = $clog2(MAX_TAPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_coef_valid,
  output logic                  s_coef_ready,
  input  logic [COEF_WIDTH-1:0] s_coef_data,
  input  logic                  s_coef_last,
  output logic                  coeff_wr_en,
  output logic [IDX_W-1:0]      coeff_index,
  output logic [COEF_WIDTH-1:0] coeff_value,
  input  logic                  din_valid_in,
  output logic                  din_valid_out,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [7:0]            drop_cnt
);

  // cnt must reach MAX_TAPS while draining, so it is one value wider than an index.
  localparam int CNT_W = $clog2(MAX_TAPS + 1);

  loader_state_t         state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CNT_W-1:0]      len, len_nxt;
  logic [COEF_WIDTH-1:0] shadow [MAX_TAPS];
  logic                  beat;
  logic                  shadow_we;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_en_nxt;
  logic [IDX_W-1:0]      index_nxt;
  logic [COEF_WIDTH-1:0] value_nxt;
  logic                  done_nxt;
  logic                  err_nxt;

  assign s_coef_ready  = !rst && (state != ST_WRITE);
  assign beat          = s_coef_valid && s_coef_ready;
  assign din_valid_out = din_valid_in && !coeff_wr_en;
  assign rd_idx        = coeff_index + 1'b1;

  // Next state and next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    len_nxt   = len;
    shadow_we = 1'b0;
    wr_en_nxt = 1'b0;
    index_nxt = '0;
    value_nxt = '0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      ST_IDLE, ST_COLLECT: begin
        if (beat) begin
          shadow_we = 1'b1;
          cnt_nxt   = cnt + 1'b1;
          state_nxt = ST_COLLECT;
          if (s_coef_last) begin
            // Tap 0 goes out on the next cycle; a one-beat set has not
            // reached the shadow bank yet, so bypass it.
            len_nxt   = cnt + 1'b1;
            state_nxt = ST_WRITE;
            wr_en_nxt = 1'b1;
            value_nxt = (cnt == '0) ? s_coef_data : shadow[0];
          end else if (cnt == CNT_W'(MAX_TAPS - 1)) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_WRITE: begin
        if (coeff_index == IDX_W'(MAX_TAPS - 1)) begin
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          wr_en_nxt = 1'b1;
          index_nxt = rd_idx;
          value_nxt = (CNT_W'(rd_idx) < len) ? shadow[rd_idx] : '0;
        end
      end
      ST_DRAIN: begin
        if (beat && s_coef_last) begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      len         <= '0;
      coeff_wr_en <= 1'b0;
      coeff_index <= '0;
      coeff_value <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      len         <= len_nxt;
      coeff_wr_en <= wr_en_nxt;
      coeff_index <= index_nxt;
      coeff_value <= value_nxt;
      load_done   <= done_nxt;
      load_err    <= err_nxt;
      busy        <= (state_nxt != ST_IDLE);
    end
  end

  // Shadow bank; contents need no reset because unused taps are zero-filled.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow[cnt[IDX_W-1:0]] <= s_coef_data;
  end

  // Saturating count of samples blocked while taps are being rewritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (din_valid_in && coeff_wr_en && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient programming front-end for the `fir` block. It receives one coefficient set per transfer from a host stream (valid/ready, tap 0 first) and buffers it in a shadow bank. It then drives the FIR's coefficient write port (`coeff_wr_en` / `coeff_index` / `coeff_value`) one tap per cycle. While taps are being rewritten it blocks `din_valid` to the FIR, so no output sample is computed from a half-updated coefficient set.

## Interface
- `COEF_WIDTH`, 16, coefficient width; must match the FIR's `COEF_WIDTH`.
- `MAX_TAPS`, 8, FIR tap count. `IDX_W = $clog2(MAX_TAPS)` is derived.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_coef_valid`  in  1  host beat valid.
- `s_coef_ready`  out  1  loader accepts a beat.
- `s_coef_data`  in  COEF_WIDTH  signed coefficient.
- `s_coef_last`  in  1  final beat of the set.
- `coeff_wr_en`  out  1  FIR coefficient write strobe.
- `coeff_index`  out  IDX_W  tap written.
- `coeff_value`  out  COEF_WIDTH  value written.
- `din_valid_in`  in  1  sample valid from upstream.
- `din_valid_out`  out  1  gated sample valid to the FIR.
- `busy`  out  1  set is being collected or written.
- `load_done`  out  1  one-cycle pulse: full set committed.
- `load_err`  out  1  one-cycle pulse: set rejected (too long).
- `drop_cnt`  out  8  saturating count of samples gated off since reset.

## Operation
- States: IDLE, COLLECT, WRITE, DRAIN.
- A beat transfers on a rising edge where `s_coef_valid && s_coef_ready`.
- `s_coef_ready` = 1 in IDLE, COLLECT and DRAIN; 0 in WRITE; 0 while `rst` = 1.
- IDLE/COLLECT:
  - Each beat is stored to `shadow[cnt]` and `cnt` increments; the first beat moves the block to COLLECT.
  - A beat with `last` and `cnt+1 <= MAX_TAPS`: store the beat, record `len = cnt+1`, go to WRITE.
  - The `MAX_TAPS`-th beat without `last`: go to DRAIN. No coefficient writes happen for this set.
- DRAIN:
  - Accept and discard beats.
  - On the beat with `last`: pulse `load_err`, clear `cnt`, go to IDLE.
- WRITE:
  - Runs for exactly `MAX_TAPS` cycles, with k = 0..MAX_TAPS-1 in order.
  - Each cycle: `coeff_wr_en`=1, `coeff_index`=k, `coeff_value` = `shadow[k]` if k < `len`, else 0. Short sets are zero-filled.
  - After the last write: pulse `load_done`, clear `cnt`, go to IDLE.
- Sample gate:
  - `din_valid_out = din_valid_in && !coeff_wr_en` (combinational).
  - `drop_cnt` increments, saturating at 255, on every cycle where `din_valid_in && coeff_wr_en`.
- `busy` = 1 in COLLECT, WRITE and DRAIN.
- The host may present back-to-back sets. A beat held during WRITE stays pending and is accepted once the block is back in IDLE.

## Timing
- Reset values: `coeff_wr_en`, `coeff_index`, `coeff_value`, `load_done`, `load_err`, `busy`, `drop_cnt` = 0; state IDLE; `cnt` = 0. Shadow contents are don't-care (always overwritten or zero-filled before use).
- `coeff_*`, `load_done`, `load_err` and `busy` are registered outputs.
- Last beat accepted at edge T:
  - `coeff_wr_en` = 1 during cycles T+1 .. T+MAX_TAPS, index 0..MAX_TAPS-1.
  - `load_done` = 1 in cycle T+MAX_TAPS+1.
  - `s_coef_ready` returns to 1 in cycle T+MAX_TAPS+1.
- `load_err` = 1 in the cycle after the DRAIN `last` beat is accepted.
- Reset mid-WRITE: writes stop in the next cycle and no `load_done` is issued. The FIR keeps any partially written taps; the host must reload.
- Reset has priority over every other event.

## Structure
- Shared package `fir_pkg`:
  - state enum `loader_state_t`;
  - default `COEF_WIDTH` / `MAX_TAPS` constants, shared with `fir`.
- No sub-module. The shadow bank is a `MAX_TAPS`-entry register array inside the block, and the whole block is a single FSM plus counters.

## Test plan
All scenarios use `MAX_TAPS` = 8, `COEF_WIDTH` = 16.
1. Send 8 beats 0x0100, 0x0200, …, 0x0800 with `last` on beat 8 -> 8 consecutive writes, index 0..7 with those values; `load_done` pulses once, exactly 9 cycles after the last beat.
2. Send 3 beats 0x7FFF, 0x8000, 0x0001 with `last` on beat 3 -> writes idx 0..2 carry those values; idx 3..7 are written as 0x0000.
3. Send 10 beats with `last` on beat 10 -> no `coeff_wr_en` at any point; `load_err` pulses after beat 10; `s_coef_ready` stays 1 throughout.
4. Hold `din_valid_in` = 1 across a full load -> `din_valid_out` is low for exactly the 8 write cycles; `drop_cnt` = 8.
5. Assert `rst` after the 3rd write -> next cycle all outputs are at reset values and state is IDLE; a following full load completes normally.
6. Hold `s_coef_valid` = 1 through WRITE -> no beat is accepted until the `load_done` cycle; the held beat becomes index 0 of the next set.
